// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel path: FSM states, halfword masks
// and the bank geometry helpers used by both led_output and fb_swap_ctrl.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_WRITE     = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_PEND = 2'd2
  } fb_state_t;

  localparam logic [1:0] MASK_RGB0 = 2'b01;
  localparam logic [1:0] MASK_RGB1 = 2'b10;
  localparam logic [1:0] MASK_BOTH = 2'b11;

  // Words per bank: each word holds one pixel from each scanline of a row pair.
  function automatic int unsigned fb_depth(input int unsigned h, input int unsigned w);
    return (h * w) / 2;
  endfunction

  // Word address width; at least one bit so degenerate panels still elaborate.
  function automatic int unsigned fb_addr_w(input int unsigned h, input int unsigned w);
    int unsigned d;
    d = fb_depth(h, w);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Double-buffered framebuffer write-side controller: host pixel writes into
// the back bank, back-bank clears, frame-aligned bank swaps and the scanner
// go level.
module fb_swap_ctrl
  import hub75_pkg::*;
#(
  parameter  int unsigned MATRIX_HEIGHT = 64,
  parameter  int unsigned MATRIX_WIDTH  = 64,
  localparam int unsigned DEPTH         = fb_depth(MATRIX_HEIGHT, MATRIX_WIDTH),
  localparam int unsigned ADDR_W        = fb_addr_w(MATRIX_HEIGHT, MATRIX_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_half,
  input  logic [15:0]       wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              clear_req,
  output logic              clear_done,
  input  logic              frame_end,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic [1:0]        ram_wmask,
  output logic              front_bank,
  output logic              go
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  fb_state_t         state, state_d;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
  logic              back_bank;

  logic              we_d;
  logic [ADDR_W:0]   waddr_d;
  logic [31:0]       wdata_d;
  logic [1:0]        wmask_d;
  logic              front_d;
  logic              go_d;
  logic              ack_d;
  logic              done_d;

  assign back_bank = ~front_bank;
  // Decoded from the state register only, so no input reaches wr_ready.
  assign wr_ready  = (state == ST_WRITE);

  // Next-state, next write-port values and status pulses.
  // The write port is registered: a handshake or clear step computed here
  // appears on ram_* one cycle later, always against the bank that is back
  // at decision time. Swaps only leave SWAP_PEND, where no write is issued,
  // so a write accepted alongside a request lands before the toggle.
  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    we_d      = 1'b0;
    waddr_d   = ram_waddr;
    wdata_d   = ram_wdata;
    wmask_d   = ram_wmask;
    front_d   = front_bank;
    go_d      = go;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    unique case (state)
      ST_WRITE: begin
        if (wr_valid) begin
          we_d    = 1'b1;
          waddr_d = {back_bank, wr_addr};
          wdata_d = {wr_data, wr_data};
          wmask_d = wr_half ? MASK_RGB1 : MASK_RGB0;
        end
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (swap_req) begin
          state_d = ST_SWAP_PEND;
        end
      end
      ST_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = {back_bank, clr_cnt};
        wdata_d = '0;
        wmask_d = MASK_BOTH;
        if (clr_cnt == CLR_LAST) begin
          clr_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = ST_WRITE;
        end else begin
          clr_cnt_d = clr_cnt + 1'b1;
        end
      end
      ST_SWAP_PEND: begin
        if (!go || frame_end) begin
          front_d = ~front_bank;
          ack_d   = 1'b1;
          go_d    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d = ST_WRITE;
      end
    endcase
  end

  // State, counter, bank select and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WRITE;
      clr_cnt    <= '0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      ram_wmask  <= '0;
      front_bank <= 1'b0;
      go         <= 1'b0;
      swap_ack   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_d;
      clr_cnt    <= clr_cnt_d;
      ram_we     <= we_d;
      ram_waddr  <= waddr_d;
      ram_wdata  <= wdata_d;
      ram_wmask  <= wmask_d;
      front_bank <= front_d;
      go         <= go_d;
      swap_ack   <= ack_d;
      clear_done <= done_d;
    end
  end

endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
Double-buffered framebuffer controller that sits in front of the `led_output` scanner. The framebuffer RAM has one read port owned by the scanner and one write port owned by this block. The bank MSB of the read address comes from `front_bank`; the host writes pixels only into the back bank. The block also handles back-buffer clears, swaps buffers only at scanner frame boundaries, and generates the scanner's `go` level.

Parameters:
- MATRIX_HEIGHT, 64, panel rows.
- MATRIX_WIDTH, 64, panel columns.
- DEPTH (derived), MATRIX_HEIGHT*MATRIX_WIDTH/2, words per bank.
- ADDR_W (derived), $clog2(DEPTH), word address width.

Ports:
- clk  in  1  single clock; all logic is posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  host pixel write request.
- wr_ready  out  1  host write accepted when valid&&ready.
- wr_addr  in  ADDR_W  word (interleaved row-pair) address.
- wr_half  in  1  0 = rgb_0 (upper scanline), 1 = rgb_1 (lower).
- wr_data  in  16  RGB565 pixel.
- swap_req  in  1  level; host holds it until swap_ack.
- swap_ack  out  1  one-cycle pulse when the banks have toggled.
- clear_req  in  1  level; host holds it until clear_done.
- clear_done  out  1  one-cycle pulse when the back-bank clear completes.
- frame_end  in  1  scanner pulse after the last row of a frame latches.
- ram_we  out  1  write strobe.
- ram_waddr  out  ADDR_W+1  {bank, word address}.
- ram_wdata  out  32  {rgb_1, rgb_0}.
- ram_wmask  out  2  bit0 = rgb_0 halfword, bit1 = rgb_1 halfword.
- front_bank  out  1  bank the scanner reads.
- go  out  1  scanner start level.

Behaviour:
- **Reset (async, may assert mid-operation):**
  - State returns to WRITE; any CLEAR or SWAP_PEND in progress is aborted.
  - front_bank=0, go=0, ram_we=0, ram_waddr=0, ram_wdata=0, ram_wmask=0.
  - swap_ack=0, clear_done=0, clear counter=0.
  - wr_ready=1 in the first cycle after reset.
- **Derived signals:**
  - back_bank = ~front_bank.
  - wr_ready = (state==WRITE), decoded from the state register only, with no combinational path from the inputs.
- **State WRITE:**
  - A write handshake at edge k drives, during cycle k+1:
    - ram_we=1
    - ram_waddr={back_bank sampled at k, wr_addr}
    - ram_wdata={wr_data,wr_data}
    - ram_wmask = wr_half ? 2'b10 : 2'b01
  - Write latency is 1 cycle. With no handshake, ram_we=0 the next cycle.
  - If clear_req=1, go to CLEAR. clear_req has priority when both requests are high.
  - Else if swap_req=1, go to SWAP_PEND.
  - A write accepted in the same cycle as a request is still committed, and lands before any bank toggle.
- **State CLEAR:**
  - Issues DEPTH consecutive writes to addresses 0..DEPTH-1 of back_bank, one per cycle, with data 0 and mask 2'b11.
  - After the final write: clear_done pulses for 1 cycle and the state returns to WRITE.
  - swap_req and frame_end are ignored while in CLEAR.
- **State SWAP_PEND:**
  - wr_ready=0.
  - If go==0 (scanner not yet running) or frame_end==1: at the next edge front_bank toggles, swap_ack=1 for exactly that cycle, go is set to 1 (sticky until reset), and the state returns to WRITE.
  - Otherwise the block waits indefinitely.
- **frame_end outside SWAP_PEND:** ignored.
- **Request sampling:** requests are sampled only in WRITE. On its return to WRITE, the FSM samples a request still held after its ack/done as a new request; the host must deassert it the cycle the ack/done is seen.
- **Counter:** the clear counter wraps at DEPTH-1. Terminal detection compares against DEPTH-1; there is no overflow beyond ADDR_W bits.
- **Invariant:** ram_we never targets front_bank.

Decomposition:
- Shared package `hub75_pkg` holds:
  - FSM state encoding (WRITE, CLEAR, SWAP_PEND) as 2-bit localparams.
  - Halfword mask constants.
  - Helper functions for DEPTH and ADDR_W, so `led_output` and this block agree on address width.
- Single module; no sub-module is warranted. The write-register stage and clear counter live inline.

Test Plan (MATRIX_HEIGHT=4, MATRIX_WIDTH=4, DEPTH=8, ADDR_W=3):
1. Assert rst for 3 cycles, then release → front_bank=0, go=0, wr_ready=1, ram_we=0, swap_ack=0, clear_done=0.
2. Write wr_addr=3, wr_half=1, wr_data=16'hF800 → next cycle ram_we=1, ram_waddr=4'b1011, ram_wdata[31:16]=16'hF800, ram_wmask=2'b10; the cycle after, ram_we=0.
3. Pulse swap_req with go=0 → wr_ready low for 1 cycle; swap_ack pulses 2 cycles after the request edge; front_bank=1, go=1; a subsequent write to addr 0 produces ram_waddr=4'b0000.
4. With go=1, hold swap_req and inject frame_end 20 cycles later → wr_ready=0 and front_bank unchanged for those 20 cycles; swap_ack and the front_bank toggle occur on the edge after frame_end.
5. Raise clear_req and swap_req together, back bank 1 → 8 consecutive ram_we cycles with ram_waddr 4'b1000..4'b1111, data 0, mask 2'b11; clear_done pulses; the swap then proceeds and swap_ack follows.
6. Assert rst after the 3rd clear write → ram_we=0 immediately (async); after release front_bank=0, go=0, no clear_done pulse, wr_ready=1.
